// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the serial UART transmitter.
//   tx_state_t      - transmitter FSM states (PARITY only used when the
//                     UART_TX_PARITY_EN build macro is defined)
//   UART_DATA_BITS  - data bits per frame
//   UART_IDLE_LEVEL - level of the serial line when nothing is being sent
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy counter.
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset (empties the FIFO)
//   push       - write push_data when not full
//   push_data  - WIDTH-bit write data
//   pop        - advance read pointer when not empty
//   pop_data   - WIDTH-bit head entry (valid while !empty)
//   full/empty - occupancy flags derived from the registered level
//   level      - number of occupied entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign full     = (level_q == FULL_LEVEL);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_phy.sv
// uart_tx_phy: byte-stream to serial-line UART transmitter.
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   tx_data    - byte to send
//   tx_valid   - tx_data valid; accepted when tx_ready is high
//   tx_ready   - FIFO not full
//   txd        - registered serial output, idles high
//   busy       - a frame is in progress or bytes are queued
//   fifo_level - number of queued bytes
// Frame format is 8N1. Defining the build macro UART_TX_PARITY_EN inserts an
// even-parity bit before the stop bit (8E1).
import uart_pkg::*;

module uart_tx_phy #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int               CNT_W      = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       LAST_BIT   = 3'(UART_DATA_BITS - 1);

    tx_state_t                  state_q, state_d;
    logic [CNT_W-1:0]           baud_cnt_q, baud_cnt_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic                       txd_q, txd_d;
    logic                       bit_end;
    logic                       fifo_pop, fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0]  fifo_head;
`ifdef UART_TX_PARITY_EN
    logic                       parity_q, parity_d;
`endif

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign txd      = txd_q;
    assign bit_end  = (baud_cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!fifo_empty) state_d = START;
            START:  if (bit_end) state_d = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_end && bit_cnt_q == LAST_BIT) state_d = PARITY;
            PARITY: if (bit_end) state_d = STOP;
`else
            DATA:   if (bit_end && bit_cnt_q == LAST_BIT) state_d = STOP;
`endif
            STOP:   if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Baud counter, bit counter, shift register and FIFO pop.
    // The pop happens only from IDLE, i.e. from registered non-empty state,
    // so it can never collide with the first push into an empty FIFO.
    always_comb begin
        fifo_pop   = 1'b0;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q == IDLE) begin
            baud_cnt_d = '0;
            if (!fifo_empty) begin
                fifo_pop   = 1'b1;
                shift_d    = fifo_head;
                baud_cnt_d = CNT_RELOAD;
                bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
                parity_d   = ^fifo_head;
`endif
            end
        end else begin
            baud_cnt_d = bit_end ? CNT_RELOAD : baud_cnt_q - CNT_W'(1);
            if (state_q == DATA && bit_end) begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    // Output logic: txd is registered, so the line follows the state by one clock.
    always_comb begin
        txd_d = UART_IDLE_LEVEL;
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = parity_q;
`endif
            default: txd_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            txd_q      <= UART_IDLE_LEVEL;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            txd_q      <= txd_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

endmodule

// File: tb/tb_uart_tx_phy.sv
`timescale 1ns/1ps
module tb_uart_tx_phy;

    localparam int CD    = 4;
    localparam int CD2   = 2;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_level;

    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       txd2;
    logic       busy2;
    logic [2:0] fifo_level2;

    uart_tx_phy #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    uart_tx_phy #(.CLK_DIV(CD2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .txd        (txd2),
        .busy       (busy2),
        .fifo_level (fifo_level2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;   // bit 0 = start bit, sent first
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Line monitor: decodes every frame on txd, verifies each bit is held for
    // exactly CD clocks and compares against the scoreboard.
    int          mon_pos = -1;
    logic [10:0] mon_bits;
    logic        mon_glitch;
    logic [7:0]  mon_exp;

    always @(negedge clk) begin
        if (!rst) begin
            mon_pos = -1;
        end else begin
            if (mon_pos < 0 && txd === 1'b0) begin
                mon_pos    = 0;
                mon_bits   = '0;
                mon_glitch = 1'b0;
            end
            if (mon_pos >= 0) begin
                if (mon_pos % CD == 0) mon_bits[mon_pos / CD] = txd;
                else if (txd !== mon_bits[mon_pos / CD]) mon_glitch = 1'b1;
                mon_pos++;
                if (mon_pos == FB * CD) begin
                    mon_pos = -1;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected no frame", mon_bits);
                    end else begin
                        mon_exp = sb_q.pop_front();
                        check("sb_frame", 32'(mon_bits), 32'(frame_of(mon_exp)));
                        check("sb_bit_width_glitch", 32'(mon_glitch), 0);
                    end
                end
            end
        end
    end

    // Sends one byte into an idle block and checks txd on every clock.
    task automatic send_exact(input logic [7:0] d, input logic [10:0] fr);
        @(negedge clk);
        check("ready_before_push", 32'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        sb_q.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
        check("level_after_edge0", 32'(fifo_level), 1);
        check("txd_after_edge0", 32'(txd), 1);
        @(negedge clk);
        check("level_after_pop", 32'(fifo_level), 0);
        check("busy_after_pop", 32'(busy), 1);
        check("txd_after_edge1", 32'(txd), 1);
        for (int c = 2; c <= 1 + FB * CD; c++) begin
            @(negedge clk);
            check($sformatf("txd_%02h_cyc%0d", d, c), 32'(txd), 32'(fr[(c - 2) / CD]));
        end
        check("busy_after_frame", 32'(busy), 0);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((busy !== 1'b0 || sb_q.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", 32'(n < max_cyc), 1);
    endtask

    initial begin
        int         acc_edge[6];
        int         idx;
        int         edge_n;
        int         ready_low;
        int         n;
        int         hi_cnt;
        logic       accepted;
        logic [10:0] fr2;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'h55, 11'b1_0_01010101_0};
        vecs[1] = '{8'hA3, 11'b1_0_10100011_0};
        vecs[2] = '{8'h00, 11'b1_0_00000000_0};
        vecs[3] = '{8'hFF, 11'b1_0_11111111_0};
        vecs[4] = '{8'h07, 11'b1_1_00000111_0};
        vecs[5] = '{8'h03, 11'b1_0_00000011_0};
        vecs[6] = '{8'h0E, 11'b1_1_00001110_0};
        fr2     = 11'b1_0_10000001_0;
`else
        vecs[0] = '{8'h55, 11'b0_1_01010101_0};
        vecs[1] = '{8'hA3, 11'b0_1_10100011_0};
        vecs[2] = '{8'h00, 11'b0_1_00000000_0};
        vecs[3] = '{8'hFF, 11'b0_1_11111111_0};
        vecs[4] = '{8'h07, 11'b0_1_00000111_0};
        vecs[5] = '{8'h03, 11'b0_1_00000011_0};
        vecs[6] = '{8'h0E, 11'b0_1_00001110_0};
        fr2     = 11'b0_1_10000001_0;
`endif

        // Reset with a handshake presented: it must be ignored.
        rst       = 1'b0;
        tx_valid  = 1'b1;
        tx_data   = 8'hAA;
        tx_valid2 = 1'b0;
        tx_data2  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 1);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(tx_ready), 1);
        rst      = 1'b1;
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_level", 32'(fifo_level), 0);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_txd", 32'(txd), 1);

        // Table-driven single frames with cycle-exact waveform checks.
        for (int i = 0; i < 7; i++) send_exact(vecs[i].data, vecs[i].frame);

        // Minimum divider: 0x81 on the CLK_DIV=2 instance.
        @(negedge clk);
        check("d2_ready", 32'(tx_ready2), 1);
        tx_data2  = 8'h81;
        tx_valid2 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        check("d2_level_after_edge0", 32'(fifo_level2), 1);
        @(negedge clk);
        check("d2_busy_after_pop", 32'(busy2), 1);
        for (int c = 2; c <= 1 + FB * CD2; c++) begin
            @(negedge clk);
            check($sformatf("d2_txd_cyc%0d", c), 32'(txd2), 32'(fr2[(c - 2) / CD2]));
        end
        check("d2_busy_after_frame", 32'(busy2), 0);
        repeat (3) @(negedge clk);
        check("d2_txd_idle", 32'(txd2), 1);

        // Back-to-back 'A'..'F' with tx_valid held: FIFO fills, stalls, resumes.
        idx       = 0;
        edge_n    = 0;
        ready_low = 0;
        @(negedge clk);
        while (idx < 6 && edge_n < 300) begin
            tx_data  = 8'(32'h41 + idx);
            tx_valid = 1'b1;
            accepted = 1'b0;
            if (tx_ready) begin
                acc_edge[idx] = edge_n;
                sb_q.push_back(tx_data);
                accepted = 1'b1;
            end else begin
                ready_low++;
            end
            @(negedge clk);
            edge_n++;
            if (accepted) idx++;
        end
        tx_valid = 1'b0;
        check("b2b_all_accepted", 32'(idx), 6);
        for (int i = 0; i < 5; i++) check($sformatf("b2b_accept_edge_%0d", i), 32'(acc_edge[i]), 32'(i));
        check("b2b_accept_edge_F", 32'(acc_edge[5]), 32'(FB * CD + 3));
        check("b2b_ready_low_cycles", 32'(ready_low), 32'(FB * CD - 2));
        wait_drain(600);

        // Inter-frame gap between two queued bytes 0x00 and 0xFF.
        @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        sb_q.push_back(8'h00);
        @(negedge clk);
        tx_data = 8'hFF;
        sb_q.push_back(8'hFF);
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (txd !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("gap_first_start_seen", 32'(n < 20), 1);
        repeat ((FB - 1) * CD) @(negedge clk);
        hi_cnt = 0;
        while (txd === 1'b1 && hi_cnt < 50) begin
            hi_cnt++;
            @(negedge clk);
        end
        check("gap_high_clocks", 32'(hi_cnt), 32'(CD + 1));
        wait_drain(200);

        // Reset in the middle of the DATA bits of 0xA3 with two bytes queued.
        @(negedge clk);
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        sb_q.push_back(8'hA3);
        @(negedge clk);
        tx_data = 8'h11;
        sb_q.push_back(8'h11);
        @(negedge clk);
        tx_data = 8'h22;
        sb_q.push_back(8'h22);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3 * CD) @(negedge clk);
        check("mid_frame_level", 32'(fifo_level), 2);
        check("mid_frame_txd_bit2", 32'(txd), 0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_txd", 32'(txd), 1);
        check("async_rst_level", 32'(fifo_level), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_ready", 32'(tx_ready), 1);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("after_rst_idle_txd", 32'(txd), 1);
        check("after_rst_idle_busy", 32'(busy), 0);
`ifdef UART_TX_PARITY_EN
        send_exact(8'h12, 11'b1_0_00010010_0);
`else
        send_exact(8'h12, 11'b0_1_00010010_0);
`endif
        wait_drain(100);

        check("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_phy.md
# uart_tx_phy

Serial UART transmitter that sits on the far side of the memory-mapped UART's byte stream. It accepts bytes over a valid/ready handshake, buffers them in a small FIFO and serializes each byte onto a single `txd` line as an 8N1 frame. The baud rate comes from a clock divider. Together with the memory-mapped UART it turns CPU store traffic into a physical serial line.

## Interface
Parameters:
- `CLK_DIV`, default 868: clocks per serial bit. Legal range is CLK_DIV >= 2. The default gives 115200 baud at 100 MHz.
- `FIFO_DEPTH`, default 16: byte entries in the FIFO. Must be a power of 2 and >= 2.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte. Equals !full.
- `txd`  out  1  serial output, registered. Idle level is 1.
- `busy`  out  1  Equals (state != IDLE) || !empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

## Operation
- **Push:** a byte is written when tx_valid && tx_ready on a rising edge. tx_ready is derived from registered occupancy only.
  - When full, tx_ready=0, even if a pop occurs in the same cycle.
- **FSM states:** IDLE, START, DATA, STOP, plus PARITY (see Configuration).
- **IDLE:** txd=1. If the FIFO is non-empty, pop the head into the 8-bit shift register, load the baud counter with CLK_DIV-1, and move to START next cycle.
- **START:** txd=0.
- **DATA:** txd=shift[0], LSB first. Shift right on each bit boundary. A 3-bit counter tracks 8 bits.
- **STOP:** txd=1. Then return to IDLE.
- **Baud counter:** width $clog2(CLK_DIV). It counts down each clock. At 0 the current bit ends, the counter reloads CLK_DIV-1, and the FSM advances. Every bit lasts exactly CLK_DIV clocks.
- **Full/empty:** pop only occurs from registered non-empty state, so a push to an empty FIFO and a pop never coincide. Simultaneous push and pop with 0 < level < DEPTH leaves the level unchanged.
- **Pointers:** $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
- **Reset values:**
  - txd=1, state=IDLE, counters 0, FIFO empty.
  - fifo_level=0, busy=0, tx_ready=1.
  - Handshakes while rst=0 are discarded.
- **Reset mid-frame:** txd returns to 1 asynchronously. Queued bytes are dropped. No partial frame resumes.

## Timing
- **Handshake to start bit:** for a byte accepted at edge 0 into an empty, idle block:
  - fifo_level=1 after edge 0.
  - Pop at edge 1.
  - txd=0 after edge 2.
- **Frame length:** 10*CLK_DIV clocks, or 11*CLK_DIV with parity.
- **Inter-frame gap:** with back-to-back queued bytes, txd stays high for CLK_DIV+1 clocks between frames (stop bit plus one IDLE pop cycle).
- **Throughput:** one byte per (10*CLK_DIV+1) clocks sustained.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- **Defined:** a PARITY state is inserted between DATA and STOP. txd = XOR of the 8 data bits (even parity) for CLK_DIV clocks. The frame is 8E1.
- **Undefined:** no PARITY state and no parity logic. The frame is 8N1.

## Structure
- **Package `uart_pkg`:**
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - `UART_DATA_BITS`=8.
  - `UART_IDLE_LEVEL`=1'b1.
- **Sub-module `sync_fifo`:** parameterized width/depth, ports push/pop/full/empty/level. The top contains the FSM, baud counter and shift register.

## Test plan
- CLK_DIV=4, FIFO_DEPTH=4, send 0x55 -> txd=0 from cycle 2 and holds each bit value for 4 clocks: 0,1,0,1,0,1,0,1,0,1. txd=1 and busy=0 after cycle 41.
- Hold tx_valid with bytes A..F on consecutive cycles -> A..E accepted on edges 0-4. tx_ready=0 from cycle 5 until B is popped. Bytes emerge in order A..F.
- Two queued bytes 0x00, 0xFF -> txd high for exactly CLK_DIV+1 clocks between the first stop bit start and the second start bit.
- Assert rst mid-DATA of 0xA3 with 2 bytes queued -> txd=1 and fifo_level=0 immediately, busy=0. After release, a new byte 0x12 is sent correctly.
- With `UART_TX_PARITY_EN`: 0x07 -> parity bit 1; 0x03 -> parity bit 0. Frame = 44 clocks at CLK_DIV=4.
- CLK_DIV=2 minimum -> 0x81 gives bit widths of exactly 2 clocks. Counter never underflows.
